// File: rtl/axis_fifo_group_sched_if.sv
// Select/handshake bundle between the per-function FIFO group, its upstream logic and the RR scheduler.
// master drives the fire/enable strobes; slave (the scheduler) returns the grant and status.
interface axis_fifo_group_sched_if #(
  parameter int FUNC_WIDTH = 8
);
  logic                  enq_fire;
  logic [FUNC_WIDTH-1:0] enq_func;
  logic                  deq_fire;
  logic                  sched_enable;
  logic [FUNC_WIDTH-1:0] curr_func_out;
  logic                  curr_func_out_valid;
  logic                  pending_any;
  logic                  err_underflow;

  modport master (
    output enq_fire, enq_func, deq_fire, sched_enable,
    input  curr_func_out, curr_func_out_valid, pending_any, err_underflow
  );

  modport slave (
    input  enq_fire, enq_func, deq_fire, sched_enable,
    output curr_func_out, curr_func_out_valid, pending_any, err_underflow
  );
endinterface

// File: rtl/axis_fifo_group_sched.sv
// Round-robin output select for the FIFO group: grant valid 2 cycles after pending_any rises, one ARB bubble per switch.
// A grant holds while deq_fire stalls (no timeout) and ends on quantum, empty function or sched_enable low.
module axis_fifo_group_sched #(
  parameter  int NUM_FUNCS  = 256,
  parameter  int CNT_WIDTH  = 13,
  parameter  int QUANTUM    = 16,
  localparam int FUNC_WIDTH = $clog2(NUM_FUNCS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_fifo_group_sched_if.slave  sif
);

  localparam int BEAT_WIDTH = $clog2(QUANTUM + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [BEAT_WIDTH-1:0] BEAT_ONE  = BEAT_WIDTH'(1);
  localparam logic [BEAT_WIDTH-1:0] BEAT_LAST = BEAT_WIDTH'(QUANTUM - 1);
  localparam logic [FUNC_WIDTH-1:0] FUNC_ONE  = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] FUNC_LAST = FUNC_WIDTH'(NUM_FUNCS - 1);

  logic [CNT_WIDTH-1:0]  pending     [NUM_FUNCS];
  logic [CNT_WIDTH-1:0]  pending_nxt [NUM_FUNCS];
  logic [NUM_FUNCS-1:0]  inc_vec;
  logic [NUM_FUNCS-1:0]  dec_vec;
  logic [NUM_FUNCS-1:0]  nonempty;
  logic [NUM_FUNCS-1:0]  nonempty_nxt;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [FUNC_WIDTH-1:0] curr_func;
  logic [FUNC_WIDTH-1:0] rr_ptr;
  logic [FUNC_WIDTH-1:0] pick_func;
  logic                  pick_found;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic                  err_q;
  logic                  granted;
  logic                  deq_granted;
  logic                  underflow;
  logic                  quantum_hit;
  logic                  grant_exit;
  logic                  pending_any_q;

  assign granted     = (state == ST_GRANT);
  assign deq_granted = sif.deq_fire && granted;
  assign underflow   = sif.deq_fire && (!granted || (pending[curr_func] == '0));

  always_comb begin
    for (int f = 0; f < NUM_FUNCS; f++) begin
      inc_vec[f] = sif.enq_fire && (sif.enq_func == FUNC_WIDTH'(f));
      dec_vec[f] = deq_granted && (curr_func == FUNC_WIDTH'(f));
    end
  end

  // Same-function enq+deq cancel; otherwise saturate up / floor at zero down.
  always_comb begin
    for (int f = 0; f < NUM_FUNCS; f++) begin
      pending_nxt[f] = pending[f];
      if (inc_vec[f] && !dec_vec[f]) begin
        if (pending[f] != CNT_MAX) pending_nxt[f] = pending[f] + CNT_ONE;
      end else if (dec_vec[f] && !inc_vec[f]) begin
        if (pending[f] != '0) pending_nxt[f] = pending[f] - CNT_ONE;
      end
      nonempty[f]     = (pending[f] != '0);
      nonempty_nxt[f] = (pending_nxt[f] != '0);
    end
  end

  assign pending_any_q = |nonempty;

  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_func  = rr_ptr;
    for (int i = 0; i < NUM_FUNCS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_FUNCS) idx = idx - NUM_FUNCS;
      if (!pick_found && nonempty[idx]) begin
        pick_found = 1'b1;
        pick_func  = FUNC_WIDTH'(idx);
      end
    end
  end

  assign quantum_hit = sif.deq_fire && (beat_cnt == BEAT_LAST);
  assign grant_exit  = quantum_hit || !nonempty_nxt[curr_func] || !sif.sched_enable;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pending_any_q && sif.sched_enable) state_nxt = ST_ARB;
      ST_ARB:   state_nxt = pick_found ? ST_GRANT : ST_IDLE;
      ST_GRANT: begin
        if (grant_exit) state_nxt = ((|nonempty_nxt) && sif.sched_enable) ? ST_ARB : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      curr_func <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
      for (int f = 0; f < NUM_FUNCS; f++) pending[f] <= '0;
    end else begin
      state <= state_nxt;
      for (int f = 0; f < NUM_FUNCS; f++) pending[f] <= pending_nxt[f];
      if (underflow) err_q <= 1'b1;
      case (state)
        ST_ARB: begin
          if (pick_found) begin
            curr_func <= pick_func;
            beat_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (sif.deq_fire) beat_cnt <= beat_cnt + BEAT_ONE;
          if (grant_exit) rr_ptr <= (curr_func == FUNC_LAST) ? '0 : curr_func + FUNC_ONE;
        end
        default: ;
      endcase
    end
  end

  assign sif.curr_func_out       = curr_func;
  assign sif.curr_func_out_valid = granted;
  assign sif.pending_any         = pending_any_q;
  assign sif.err_underflow       = err_q;

endmodule

// File: tb/tb_axis_fifo_group_sched.sv
// Bench for axis_fifo_group_sched: directed scenarios plus random traffic, with per-cycle expected outputs
// from a queue/array reference model pushed to a scoreboard and checked by an independent monitor.
module tb_axis_fifo_group_sched;

  localparam int N    = 8;
  localparam int CW   = 4;
  localparam int Q    = 4;
  localparam int FW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          v;
    logic [FW-1:0] f;
    logic          pa;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_fifo_group_sched_if #(.FUNC_WIDTH(FW)) sif ();

  axis_fifo_group_sched #(
    .NUM_FUNCS (N),
    .CNT_WIDTH (CW),
    .QUANTUM   (Q)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;

  // Reference model: word counts per function plus the grant the scheduler should hold.
  int cnt[N];
  bit m_gon;
  bit m_arb;
  bit m_err;
  int m_gf;
  int m_beats;
  int m_ptr;

  function automatic bit any_nonzero(input int c[N]);
    for (int i = 0; i < N; i++) if (c[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    m_gon = 0; m_arb = 0; m_err = 0; m_gf = 0; m_beats = 0; m_ptr = 0;
  endtask

  task automatic model_step(input bit enq, input int ef, input bit deq, input bit en);
    int nc[N];
    bit any_old;
    bit any_new;
    int f;
    nc = cnt;
    any_old = any_nonzero(cnt);
    if (deq && (!m_gon || cnt[m_gf] == 0)) m_err = 1;
    if (!(enq && deq && m_gon && ef == m_gf)) begin
      if (enq && nc[ef] < CMAX) nc[ef]++;
      if (deq && m_gon && nc[m_gf] > 0) nc[m_gf]--;
    end
    any_new = any_nonzero(nc);
    if (m_gon) begin
      if (deq) m_beats++;
      if ((deq && m_beats == Q) || nc[m_gf] == 0 || !en) begin
        m_gon = 0;
        m_ptr = (m_gf + 1) % N;
        m_arb = any_new && en;
      end
    end else if (m_arb) begin
      m_arb = 0;
      for (int k = 0; k < N; k++) begin
        f = (m_ptr + k) % N;
        if (cnt[f] != 0) begin
          m_gon = 1; m_gf = f; m_beats = 0;
          break;
        end
      end
    end else begin
      m_arb = any_old && en;
    end
    cnt = nc;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v   = m_gon;
    e.f   = FW'(m_gf);
    e.pa  = any_nonzero(cnt);
    e.err = m_err;
    return e;
  endfunction

  task automatic cyc(input bit rst, input bit enq, input int ef, input bit deq, input bit en);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n            = !rst;
    sif.enq_fire     = enq;
    sif.enq_func     = FW'(ef);
    sif.deq_fire     = deq;
    sif.sched_enable = en;
    if (rst) model_reset();
    else     model_step(enq, ef, deq, en);
    e = model_out();
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic run_auto(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, m_gon, en);
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_no, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("curr_func_out_valid", int'(sif.curr_func_out_valid), int'(e.v));
      chk("curr_func_out", int'(sif.curr_func_out), int'(e.f));
      chk("pending_any", int'(sif.pending_any), int'(e.pa));
      chk("err_underflow", int'(sif.err_underflow), int'(e.err));
    end
  end

  initial begin
    int ef;
    bit enq;
    bit hot;
    sif.enq_fire = 0; sif.enq_func = '0; sif.deq_fire = 0; sif.sched_enable = 0;
    model_reset();

    // Reset held with enq toggling, then release.
    for (int i = 0; i < 4; i++) cyc(1, i[0], i % N, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Single function: three words on func 5, drained once granted.
    for (int i = 0; i < 3; i++) cyc(0, 1, 5, m_gon, 1);
    run_auto(12, 1);

    // Round robin between funcs 2 and 7, ten words each.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2, 0, 0);
      cyc(0, 1, 7, 0, 0);
    end
    run_auto(40, 1);

    // Wrap: park the pointer at N-1, then load funcs 0 and N-1.
    cyc(0, 1, N - 2, 0, 1);
    run_auto(8, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, N - 1, 0, 0);
    run_auto(12, 1);

    // Enqueue to the granted function in the same cycle as its dequeue.
    cyc(0, 1, 3, 0, 0);
    for (int i = 0; i < 6 && !m_gon; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 3, 1, 1);
    run_auto(8, 1);

    // sched_enable dropped mid-grant, idle with work pending, then resumed.
    for (int i = 0; i < 3; i++) cyc(0, 1, 4, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 5, 0, 0);
    for (int i = 0; i < 6 && !m_gon; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    run_auto(4, 0);
    run_auto(20, 1);

    // Random traffic with hot-spot phases to reach counter saturation.
    for (int i = 0; i < 2000; i++) begin
      hot = ((i / 250) % 2) == 1;
      enq = hot ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
      ef  = hot ? $urandom_range(0, 1) : $urandom_range(0, N - 1);
      cyc(0, enq, ef, m_gon && ($urandom_range(0, 3) != 0), $urandom_range(0, 15) != 0);
    end
    run_auto(300, 1);

    // Dequeue with no grant sets the sticky error; only reset clears it.
    for (int i = 0; i < 6 && m_gon; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    run_auto(3, 1);
    cyc(0, 1, 1, 0, 1);
    run_auto(8, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
